// File: rtl/pyc_counter_arb_if.sv
// pyc_counter_arb_if: request and counter-bank bus for the shared-adder scheduler
interface pyc_counter_arb_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_delta;
  logic [N_REQ-1:0]       req_ready;
  logic                   clr;
  logic                   freeze;
  logic [N_REQ*WIDTH-1:0] count;
  logic [N_REQ-1:0]       ovf;
  logic                   busy;
  modport master (
    output req_valid, req_delta, clr, freeze,
    input  req_ready, count, ovf, busy
  );
  modport slave (
    input  req_valid, req_delta, clr, freeze,
    output req_ready, count, ovf, busy
  );
endinterface

// File: rtl/pyc_counter_arb_ctrl.sv
// pyc_counter_arb_ctrl: round-robin scheduler sharing one adder across a bank of counters
module pyc_counter_arb_ctrl #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  pyc_counter_arb_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0]                 ptr_q;
  logic [PW-1:0]                 gnt_d;
  logic                          found_d;
  logic                          xfer_d;
  logic [WIDTH:0]                sum_d;
  logic [N_REQ-1:0][WIDTH-1:0]   count_q;
  logic [N_REQ-1:0][WIDTH-1:0]   delta_w;
  logic [N_REQ-1:0]              ovf_q;
  logic                          busy_q;
  assign delta_w = bus.req_delta;
  // first valid requester searching circularly from the slot after the last grant
  always_comb begin
    found_d = 1'b0;
    gnt_d = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found_d && bus.req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        found_d = 1'b1;
        gnt_d = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end
  assign xfer_d = found_d & ~rst & ~bus.clr & ~bus.freeze;
  assign bus.req_ready = xfer_d ? (N_REQ'(1) << gnt_d) : '0;
  assign sum_d = {1'b0, count_q[gnt_d]} + {1'b0, delta_w[gnt_d]};
  // counter bank update: clear wins over grants, freeze just suppresses the grant
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q <= '0;
      busy_q <= 1'b0;
      ptr_q <= PW'(N_REQ - 1);
    end else begin
      busy_q <= |bus.req_valid;
      if (bus.clr) begin
        count_q <= '0;
        ovf_q <= '0;
      end else if (xfer_d) begin
        count_q[gnt_d] <= sum_d[WIDTH-1:0];
        ovf_q[gnt_d] <= ovf_q[gnt_d] | sum_d[WIDTH];
        ptr_q <= gnt_d;
      end
    end
  end
  assign bus.count = count_q;
  assign bus.ovf = ovf_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_pyc_counter_arb_ctrl.sv
// tb_pyc_counter_arb_ctrl: directed vector bench for the round-robin counter scheduler
module tb_pyc_counter_arb_ctrl;
  logic clk;
  logic rst;
  int checks = 0;
  int errors = 0;
  pyc_counter_arb_if #(.N_REQ(4), .WIDTH(8)) bus ();
  pyc_counter_arb_ctrl #(.N_REQ(4), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [3:0]  valid;
    logic [31:0] delta;
    logic        clr;
    logic        freeze;
    logic [3:0]  rdy;
    logic [31:0] cnt;
    logic [3:0]  ovf;
  } vec_t;
  vec_t tv[$];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction
  function automatic void add(input logic [3:0] v, input logic [31:0] d, input logic c, input logic f,
                              input logic [3:0] r, input logic [31:0] cn, input logic [3:0] o);
    vec_t x;
    x.valid = v; x.delta = d; x.clr = c; x.freeze = f; x.rdy = r; x.cnt = cn; x.ovf = o;
    tv.push_back(x);
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d, input logic c, input logic f);
    @(negedge clk);
    rst = r; bus.req_valid = v; bus.req_delta = d; bus.clr = c; bus.freeze = f;
    #1;
  endtask
  initial begin
    rst = 1'b1; bus.req_valid = '0; bus.req_delta = '0; bus.clr = 1'b0; bus.freeze = 1'b0;
    // fairness: all valid, delta 1
    add(4'b1111, pk(1,1,1,1), 0, 0, 4'b0001, pk(1,0,0,0), 4'b0000);
    add(4'b1111, pk(1,1,1,1), 0, 0, 4'b0010, pk(1,1,0,0), 4'b0000);
    add(4'b1111, pk(1,1,1,1), 0, 0, 4'b0100, pk(1,1,1,0), 4'b0000);
    add(4'b1111, pk(1,1,1,1), 0, 0, 4'b1000, pk(1,1,1,1), 4'b0000);
    add(4'b1111, pk(1,1,1,1), 0, 0, 4'b0001, pk(2,1,1,1), 4'b0000);
    add(4'b1111, pk(1,1,1,1), 0, 0, 4'b0010, pk(2,2,1,1), 4'b0000);
    add(4'b1111, pk(1,1,1,1), 0, 0, 4'b0100, pk(2,2,2,1), 4'b0000);
    add(4'b1111, pk(1,1,1,1), 0, 0, 4'b1000, pk(2,2,2,2), 4'b0000);
    // clear, then single requester 2 with delta 3
    add(4'b0000, pk(0,0,0,0), 1, 0, 4'b0000, pk(0,0,0,0), 4'b0000);
    add(4'b0100, pk(0,0,3,0), 0, 0, 4'b0100, pk(0,0,3,0), 4'b0000);
    add(4'b0100, pk(0,0,3,0), 0, 0, 4'b0100, pk(0,0,6,0), 4'b0000);
    add(4'b0100, pk(0,0,3,0), 0, 0, 4'b0100, pk(0,0,9,0), 4'b0000);
    add(4'b0100, pk(0,0,3,0), 0, 0, 4'b0100, pk(0,0,12,0), 4'b0000);
    add(4'b0100, pk(0,0,3,0), 0, 0, 4'b0100, pk(0,0,15,0), 4'b0000);
    // wrap on counter 1
    add(4'b0010, pk(0,250,0,0), 0, 0, 4'b0010, pk(0,250,15,0), 4'b0000);
    add(4'b0010, pk(0,10,0,0), 0, 0, 4'b0010, pk(0,4,15,0), 4'b0010);
    add(4'b0010, pk(0,1,0,0), 0, 0, 4'b0010, pk(0,5,15,0), 4'b0010);
    // skip: valid 1010 from ptr 1
    add(4'b1010, pk(0,1,0,2), 0, 0, 4'b1000, pk(0,5,15,2), 4'b0010);
    add(4'b1010, pk(0,1,0,2), 0, 0, 4'b0010, pk(0,6,15,2), 4'b0010);
    add(4'b1010, pk(0,1,0,2), 0, 0, 4'b1000, pk(0,6,15,4), 4'b0010);
    add(4'b1010, pk(0,1,0,2), 0, 0, 4'b0010, pk(0,7,15,4), 4'b0010);
    // freeze holds, clr overrides freeze, pointer kept at 1
    add(4'b1111, pk(1,1,1,1), 0, 1, 4'b0000, pk(0,7,15,4), 4'b0010);
    add(4'b1111, pk(1,1,1,1), 0, 1, 4'b0000, pk(0,7,15,4), 4'b0010);
    add(4'b1111, pk(1,1,1,1), 0, 1, 4'b0000, pk(0,7,15,4), 4'b0010);
    add(4'b1111, pk(1,1,1,1), 1, 1, 4'b0000, pk(0,0,0,0), 4'b0000);
    add(4'b1111, pk(1,1,1,1), 0, 0, 4'b0100, pk(0,0,1,0), 4'b0000);
    add(4'b1111, pk(1,1,1,1), 0, 0, 4'b1000, pk(0,0,1,1), 4'b0000);
    // zero delta still advances the pointer
    add(4'b1111, pk(0,1,1,1), 0, 0, 4'b0001, pk(0,0,1,1), 4'b0000);
    add(4'b1111, pk(0,1,1,1), 0, 0, 4'b0010, pk(0,1,1,1), 4'b0000);
    add(4'b0000, pk(0,0,0,0), 0, 0, 4'b0000, pk(0,1,1,1), 4'b0000);
    // reset for two cycles with everyone requesting
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b1111, pk(1,1,1,1), 1'b0, 1'b0);
      check($sformatf("rst%0d_ready", i), 32'(bus.req_ready), 32'h0);
      @(posedge clk); #1;
      check($sformatf("rst%0d_count", i), bus.count, 32'h0);
      check($sformatf("rst%0d_ovf", i), 32'(bus.ovf), 32'h0);
      check($sformatf("rst%0d_busy", i), 32'(bus.busy), 32'h0);
    end
    foreach (tv[i]) begin
      drive(1'b0, tv[i].valid, tv[i].delta, tv[i].clr, tv[i].freeze);
      check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tv[i].rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d_count", i), bus.count, tv[i].cnt);
      check($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(tv[i].ovf));
      check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(|tv[i].valid));
    end
    // reset mid-operation discards the same-cycle grant
    drive(1'b1, 4'b1111, pk(5,5,5,5), 1'b0, 1'b0);
    check("midrst_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    check("midrst_count", bus.count, 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    drive(1'b0, 4'b1111, pk(5,5,5,5), 1'b0, 1'b0);
    check("postrst_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    check("postrst_count", bus.count, pk(5,0,0,0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
